// File: rtl/audio_sample_packet_builder.sv
// Formats up to four stereo samples into one HDMI Audio Sample Packet (layout 0)
// with IEC 60958 V/U/C/P bits, and holds it until the packet scheduler acknowledges it.
module audio_sample_packet_builder #(
    parameter int unsigned BIT_WIDTH   = 16,
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned PARALLEL_IN = 4
) (
    input  logic                                              clk_pixel,
    input  logic                                              reset,
    input  logic [PARALLEL_IN-1:0][CHANNELS-1:0][BIT_WIDTH-1:0] audio_in,
    input  logic [2:0]                                        sample_count,
    input  logic                                              load,
    input  logic [191:0]                                      channel_status,
    output logic                                              in_ready,
    output logic                                              packet_valid,
    input  logic                                              packet_ack,
    output logic [23:0]                                       header,
    output logic [3:0][55:0]                                  sub,
    output logic [7:0]                                        frame_counter
);

    typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           r_state;
    logic [23:0]      r_header;
    logic [3:0][55:0] r_sub;
    logic [7:0]       r_fc;

    logic             w_accept;
    logic [2:0]       w_n;
    logic [3:0]       w_present;
    logic [3:0]       w_bstart;
    logic [3:0][7:0]  w_frame;
    logic [3:0][23:0] w_l24;
    logic [3:0][23:0] w_r24;
    logic [3:0]       w_c;
    logic [3:0]       w_pl;
    logic [3:0]       w_pr;
    logic [3:0][55:0] w_sub;
    logic [23:0]      w_header;
    logic [8:0]       w_fc_sum;
    logic [7:0]       w_fc_next;

    assign in_ready      = (r_state == EMPTY) || packet_ack;
    assign packet_valid  = (r_state == FULL);
    assign header        = r_header;
    assign sub           = r_sub;
    assign frame_counter = r_fc;

    assign w_n      = (sample_count > 3'd4) ? 3'd4 : sample_count;
    assign w_accept = load && in_ready && (sample_count != 3'd0);

    always_comb begin
        w_present = '0;
        w_bstart  = '0;
        w_frame   = '0;
        w_l24     = '0;
        w_r24     = '0;
        w_c       = '0;
        w_pl      = '0;
        w_pr      = '0;
        w_sub     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            // (frame_counter + k) mod 192 without a divider; frame_counter is always < 192
            w_frame[k[1:0]]   = (r_fc >= 8'(192 - k)) ? r_fc - 8'(192 - k) : r_fc + 8'(k);
            w_present[k[1:0]] = (k < 32'(w_n));
            w_bstart[k[1:0]]  = w_present[k[1:0]] && (w_frame[k[1:0]] == 8'd0);
            w_l24[k[1:0]]     = 24'(audio_in[k[1:0]][0]) << (24 - BIT_WIDTH);
            w_r24[k[1:0]]     = 24'(audio_in[k[1:0]][1]) << (24 - BIT_WIDTH);
            w_c[k[1:0]]       = channel_status[w_frame[k[1:0]]];
            w_pl[k[1:0]]      = (^w_l24[k[1:0]]) ^ w_c[k[1:0]];
            w_pr[k[1:0]]      = (^w_r24[k[1:0]]) ^ w_c[k[1:0]];
            if (w_present[k[1:0]]) begin
                w_sub[k[1:0]] = {w_pr[k[1:0]], w_c[k[1:0]], 2'b00,
                                 w_pl[k[1:0]], w_c[k[1:0]], 2'b00,
                                 w_r24[k[1:0]], w_l24[k[1:0]]};
            end
        end
        w_header = {w_bstart, 4'b0000, 4'b0000, w_present, 8'h02};
    end

    assign w_fc_sum  = {1'b0, r_fc} + {6'b0, w_n};
    assign w_fc_next = (w_fc_sum >= 9'd192) ? 8'(w_fc_sum - 9'd192) : w_fc_sum[7:0];

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_header <= '0;
            r_sub    <= '0;
            r_fc     <= '0;
        end else if (w_accept) begin
            r_state  <= FULL;
            r_header <= w_header;
            r_sub    <= w_sub;
            r_fc     <= w_fc_next;
        end else if ((r_state == FULL) && packet_ack) begin
            r_state  <= EMPTY;
        end
    end

endmodule

// File: tb/tb_audio_sample_packet_builder.sv
// Directed bench for audio_sample_packet_builder: vector table for single-cycle behaviour,
// hand-written sequences for block wrap and asynchronous reset.
module tb_audio_sample_packet_builder;

    logic                    clk_pixel = 1'b0;
    logic                    reset;
    logic [3:0][1:0][15:0]   audio_in;
    logic [2:0]              sample_count;
    logic                    load;
    logic [191:0]            channel_status;
    logic                    in_ready;
    logic                    packet_valid;
    logic                    packet_ack;
    logic [23:0]             header;
    logic [3:0][55:0]        sub;
    logic [7:0]              frame_counter;

    int tests = 0;
    int fails = 0;

    audio_sample_packet_builder #(
        .BIT_WIDTH(16),
        .CHANNELS(2),
        .PARALLEL_IN(4)
    ) dut (
        .clk_pixel(clk_pixel),
        .reset(reset),
        .audio_in(audio_in),
        .sample_count(sample_count),
        .load(load),
        .channel_status(channel_status),
        .in_ready(in_ready),
        .packet_valid(packet_valid),
        .packet_ack(packet_ack),
        .header(header),
        .sub(sub),
        .frame_counter(frame_counter)
    );

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic                  ld;
        logic                  ack;
        logic [2:0]            cnt;
        logic [3:0][1:0][15:0] aud;
        logic                  e_rdy;
        logic                  e_valid;
        logic [23:0]           e_hdr;
        logic [3:0][55:0]      e_sub;
        logic [7:0]            e_fc;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [3:0][1:0][15:0] pk(input logic [15:0] l0, input logic [15:0] r0,
                                                 input logic [15:0] l1, input logic [15:0] r1,
                                                 input logic [15:0] l2, input logic [15:0] r2,
                                                 input logic [15:0] l3, input logic [15:0] r3);
        return {r3, l3, r2, l2, r1, l1, r0, l0};
    endfunction

    task automatic chk(input string name, input logic [55:0] act, input logic [55:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_valid, input logic [23:0] e_hdr,
                                 input logic [3:0][55:0] e_sub, input logic [7:0] e_fc);
        chk({tag, " valid"}, 56'(packet_valid), 56'(e_valid));
        chk({tag, " header"}, 56'(header), 56'(e_hdr));
        for (int k = 0; k < 4; k++) chk($sformatf("%s sub%0d", tag, k), sub[k], e_sub[k]);
        chk({tag, " fc"}, 56'(frame_counter), 56'(e_fc));
    endtask

    task automatic step(input logic ld, input logic ack, input logic [2:0] cnt,
                        input logic [3:0][1:0][15:0] aud);
        load = ld;
        packet_ack = ack;
        sample_count = cnt;
        audio_in = aud;
        @(posedge clk_pixel);
        #1;
        load = 1'b0;
        packet_ack = 1'b0;
    endtask

    initial begin
        // bit 0 only: C=1 in frame 0, C=0 in every other frame
        channel_status = 192'd1;
        load = 1'b0;
        packet_ack = 1'b0;
        sample_count = 3'd0;
        audio_in = '0;

        vecs[0] = '{ld: 1'b1, ack: 1'b0, cnt: 3'd2, aud: pk(16'h1234, 16'h8001, 0, 0, 0, 0, 0, 0),
                    e_rdy: 1'b1, e_valid: 1'b1, e_hdr: 24'h10_03_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'hC4_800100_123400}, e_fc: 8'd2};
        vecs[1] = '{ld: 1'b1, ack: 1'b0, cnt: 3'd3, aud: pk(16'hFFFF, 16'h5555, 16'h1, 16'h2, 16'h3, 0, 0, 0),
                    e_rdy: 1'b0, e_valid: 1'b1, e_hdr: 24'h10_03_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'hC4_800100_123400}, e_fc: 8'd2};
        vecs[2] = '{ld: 1'b0, ack: 1'b1, cnt: 3'd0, aud: '0,
                    e_rdy: 1'b1, e_valid: 1'b0, e_hdr: 24'h10_03_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'hC4_800100_123400}, e_fc: 8'd2};
        vecs[3] = '{ld: 1'b1, ack: 1'b0, cnt: 3'd0, aud: pk(16'hAAAA, 16'hBBBB, 0, 0, 0, 0, 0, 0),
                    e_rdy: 1'b1, e_valid: 1'b0, e_hdr: 24'h10_03_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'hC4_800100_123400}, e_fc: 8'd2};
        vecs[4] = '{ld: 1'b1, ack: 1'b0, cnt: 3'd1, aud: pk(16'h0001, 16'h0003, 0, 0, 0, 0, 0, 0),
                    e_rdy: 1'b1, e_valid: 1'b1, e_hdr: 24'h00_01_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'h08_000300_000100}, e_fc: 8'd3};
        vecs[5] = '{ld: 1'b1, ack: 1'b1, cnt: 3'd1, aud: pk(16'h8000, 16'h0000, 16'h1, 16'h1, 0, 0, 0, 0),
                    e_rdy: 1'b1, e_valid: 1'b1, e_hdr: 24'h00_01_02,
                    e_sub: {56'h0, 56'h0, 56'h0, 56'h08_000000_800000}, e_fc: 8'd4};
        vecs[6] = '{ld: 1'b1, ack: 1'b1, cnt: 3'd7,
                    aud: pk(16'h0003, 16'h0007, 16'h00F0, 16'h0000, 16'h0100, 16'h0101, 16'hFFFF, 16'h7FFF),
                    e_rdy: 1'b1, e_valid: 1'b1, e_hdr: 24'h00_0F_02,
                    e_sub: {56'h80_7FFF00_FFFF00, 56'h08_010100_010000,
                            56'h00_000000_00F000, 56'h80_000700_000300}, e_fc: 8'd8};
        vecs[7] = '{ld: 1'b0, ack: 1'b1, cnt: 3'd0, aud: '0,
                    e_rdy: 1'b1, e_valid: 1'b0, e_hdr: 24'h00_0F_02,
                    e_sub: {56'h80_7FFF00_FFFF00, 56'h08_010100_010000,
                            56'h00_000000_00F000, 56'h80_000700_000300}, e_fc: 8'd8};

        reset = 1'b1;
        #12;
        check_outputs("reset", 1'b0, 24'h0, '0, 8'd0);
        chk("reset in_ready", 56'(in_ready), 56'd1);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            load = vecs[i].ld;
            packet_ack = vecs[i].ack;
            sample_count = vecs[i].cnt;
            audio_in = vecs[i].aud;
            #1;
            chk($sformatf("v%0d in_ready", i), 56'(in_ready), 56'(vecs[i].e_rdy));
            @(posedge clk_pixel);
            #1;
            check_outputs($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_hdr, vecs[i].e_sub, vecs[i].e_fc);
            load = 1'b0;
            packet_ack = 1'b0;
        end

        // 45 acknowledged n=4 loads take frame_counter from 8 to 188
        for (int i = 0; i < 45; i++) begin
            step(1'b1, 1'b1, 3'd4, '0);
            chk($sformatf("run1 fc%0d", i), 56'(frame_counter), 56'(8 + 4 * (i + 1)));
        end
        step(1'b1, 1'b1, 3'd4, '0);
        check_outputs("wrap188", 1'b1, 24'h00_0F_02, '0, 8'd0);
        step(1'b1, 1'b1, 3'd2, '0);
        check_outputs("after_wrap", 1'b1, 24'h10_03_02, {56'h0, 56'h0, 56'h0, 56'hCC_000000_000000}, 8'd2);

        // 47 more n=4 loads reach 190, so the block start lands on subpacket 2
        for (int i = 0; i < 47; i++) step(1'b1, 1'b1, 3'd4, '0);
        chk("run2 fc", 56'(frame_counter), 56'd190);
        step(1'b1, 1'b1, 3'd4, '0);
        check_outputs("wrap190", 1'b1, 24'h40_0F_02, {56'h0, 56'hCC_000000_000000, 56'h0, 56'h0}, 8'd2);

        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 3'd4, '0);
        step(1'b1, 1'b1, 3'd2, '0);
        chk("pre-reset fc", 56'(frame_counter), 56'd100);
        chk("pre-reset valid", 56'(packet_valid), 56'd1);

        #2;
        reset = 1'b1;
        #1;
        check_outputs("async_reset", 1'b0, 24'h0, '0, 8'd0);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 3'd1, '0);
        check_outputs("post_reset", 1'b1, 24'h10_01_02, {56'h0, 56'h0, 56'h0, 56'hCC_000000_000000}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
